// File: rtl/multicycle_core_ris.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multicycle_core_ris
//  Description : Multi-cycle RV32 core for R-, I- (ALU, load) and S-type
//                instructions. Fetch and data share one ready-handshaked
//                memory port. Unsupported or misaligned operations halt the
//                core in a sticky trap state.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_core_ris #(
   parameter int          NREG     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc,
   output logic [31:0] result,
   output logic        zero,
   output logic        retire,
   output logic        trap
);

   localparam int         RW     = $clog2(NREG);
   localparam logic [5:0] NREG_W = 6'(NREG);
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] ir, a, b, imm, mdr;
   logic [31:0] regs [NREG];

   // Instruction fields
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        is_load, is_store, is_mem;

   assign opcode   = ir[6:0];
   assign rd       = ir[11:7];
   assign funct3   = ir[14:12];
   assign rs1      = ir[19:15];
   assign rs2      = ir[24:20];
   assign funct7   = ir[31:25];
   assign is_load  = (opcode == OP_LD);
   assign is_store = (opcode == OP_ST);
   assign is_mem   = is_load | is_store;

   logic        legal, uses_rs2, uses_rd, idx_bad;
   logic [31:0] imm_gen;

   // Opcode/funct legality and which register fields are meaningful
   always_comb begin
      legal    = 1'b0;
      uses_rs2 = 1'b0;
      uses_rd  = 1'b0;
      case (opcode)
         OP_R: begin
            uses_rs2 = 1'b1;
            uses_rd  = 1'b1;
            legal    = (funct7 == 7'h00) ||
                       (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101));
         end
         OP_I: begin
            uses_rd = 1'b1;
            case (funct3)
               3'b001:  legal = (funct7 == 7'h00);
               3'b101:  legal = (funct7 == 7'h00) || (funct7 == 7'h20);
               default: legal = 1'b1;
            endcase
         end
         OP_LD: begin
            uses_rd = 1'b1;
            legal   = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b101);
         end
         OP_ST: begin
            uses_rs2 = 1'b1;
            legal    = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
         end
         default: legal = 1'b0;
      endcase
   end

   // Register indices beyond the implemented file (RV32E) are illegal
   assign idx_bad = ({1'b0, rs1} >= NREG_W) ||
                    (uses_rs2 && ({1'b0, rs2} >= NREG_W)) ||
                    (uses_rd  && ({1'b0, rd}  >= NREG_W));

   assign imm_gen = is_store ? {{20{ir[31]}}, ir[31:25], ir[11:7]}
                             : {{20{ir[31]}}, ir[31:20]};

   // ALU: address generation for memory ops, otherwise R/I arithmetic
   logic [31:0] op2, alu;
   logic [4:0]  shamt;
   logic        misaligned;

   assign op2   = (opcode == OP_R) ? b : imm;
   assign shamt = op2[4:0];

   // Combinational ALU
   always_comb begin
      alu = 32'd0;
      if (is_mem) begin
         alu = a + imm;
      end else begin
         case (funct3)
            3'b000:  alu = (opcode == OP_R && funct7[5]) ? (a - op2) : (a + op2);
            3'b001:  alu = a << shamt;
            3'b010:  alu = {31'd0, ($signed(a) < $signed(op2))};
            3'b011:  alu = {31'd0, (a < op2)};
            3'b100:  alu = a ^ op2;
            3'b101:  alu = funct7[5] ? 32'($signed(a) >>> shamt) : (a >> shamt);
            3'b110:  alu = a | op2;
            default: alu = a & op2;
         endcase
      end
   end

   assign misaligned = is_mem &&
                       (((funct3[1:0] == 2'b01) && alu[0]) ||
                        ((funct3[1:0] == 2'b10) && (alu[1:0] != 2'b00)));

   // Store lane placement and load extraction, both keyed by result[1:0]
   logic [31:0] st_data, ld_shift, ld_val, wb_data;
   logic [3:0]  st_strb;

   // Store data replication and byte strobes
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            st_data = {4{b[7:0]}};
            st_strb = 4'b0001 << result[1:0];
         end
         2'b01: begin
            st_data = {2{b[15:0]}};
            st_strb = result[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_data = b;
            st_strb = 4'b1111;
         end
      endcase
   end

   assign ld_shift = mdr >> {result[1:0], 3'b000};

   // Load sign/zero extension
   always_comb begin
      case (funct3)
         3'b000:  ld_val = {{24{ld_shift[7]}},  ld_shift[7:0]};
         3'b001:  ld_val = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_val = {24'd0, ld_shift[7:0]};
         3'b101:  ld_val = {16'd0, ld_shift[15:0]};
         default: ld_val = ld_shift;
      endcase
   end

   assign wb_data = is_load ? ld_val : result;

   // Next-state logic and bus/retire outputs
   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc;
      mem_wdata = 32'd0;
      mem_wstrb = 4'b0000;
      retire    = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            state_nxt = (!legal || idx_bad) ? S_TRAP : S_EXEC;
         end
         S_EXEC: begin
            if (misaligned)  state_nxt = S_TRAP;
            else if (is_mem) state_nxt = S_MEM;
            else             state_nxt = S_WB;
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_addr = {result[31:2], 2'b00};
            if (is_store) begin
               mem_we    = 1'b1;
               mem_wdata = st_data;
               mem_wstrb = st_strb;
            end
            if (mem_ready) begin
               if (is_store) begin
                  retire    = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end
         end
         S_WB: begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_TRAP;
      endcase
      // An asynchronous reset withdraws any outstanding request at once
      if (rst) begin
         mem_req = 1'b0;
         mem_we  = 1'b0;
      end
   end

   // State, PC and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_FETCH;
         pc     <= RESET_PC;
         ir     <= 32'd0;
         a      <= 32'd0;
         b      <= 32'd0;
         imm    <= 32'd0;
         mdr    <= 32'd0;
         result <= 32'd0;
      end else begin
         state <= state_nxt;
         case (state)
            S_FETCH:  if (mem_ready) ir <= mem_rdata;
            S_DECODE: begin
               a   <= regs[rs1[RW-1:0]];
               b   <= regs[rs2[RW-1:0]];
               imm <= imm_gen;
            end
            S_EXEC:   result <= alu;
            S_MEM:    if (mem_ready && !is_store) mdr <= mem_rdata;
            default:  ;
         endcase
         if (retire) pc <= pc + 32'd4;
      end
   end

   // Register file; x0 is never written so it always reads 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= 32'd0;
      end else if (state == S_WB && rd != 5'd0) begin
         regs[rd[RW-1:0]] <= wb_data;
      end
   end

   assign zero = (result == 32'd0);
   assign trap = (state == S_TRAP);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core_ris.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_core_ris
//  Description : Self-checking bench for multicycle_core_ris. Expected bus
//                writes are queued as programs are loaded and popped as the
//                core performs them; timing and trap behaviour are checked
//                directly against bench-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_core_ris;

   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [31:0] E_PC = 32'h0000_0200;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] pc, result;
   logic        zero, retire, trap;

   logic        e_req, e_we, e_zero, e_retire, e_trap;
   logic [31:0] e_addr, e_wdata, e_pc, e_result;
   logic [3:0]  e_wstrb;

   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   assign mem_rdata = mem[mem_addr[9:2]];

   multicycle_core_ris #(.NREG(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ready(ready),
      .pc(pc), .result(result), .zero(zero), .retire(retire), .trap(trap)
   );

   // RV32E instance fed a constant ADD x17,x1,x2
   multicycle_core_ris #(.NREG(16), .RESET_PC(E_PC)) dut_e (
      .clk(clk), .rst(rst),
      .mem_req(e_req), .mem_we(e_we), .mem_addr(e_addr),
      .mem_wdata(e_wdata), .mem_wstrb(e_wstrb),
      .mem_rdata({7'h00, 5'd2, 5'd1, 3'b000, 5'd17, 7'h33}), .mem_ready(1'b1),
      .pc(e_pc), .result(e_result), .zero(e_zero), .retire(e_retire), .trap(e_trap)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] data;
   } wr_t;

   wr_t sb_q[$];
   int  ret_edges[$];
   int  n_cmp = 0, n_err = 0;
   int  edges = 0, n_ret = 0, e_ret = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk) edges <= edges + 1;

   // Bus monitor / memory model: writes commit here and are scored
   always @(negedge clk) begin
      wr_t e;
      if (retire) begin
         n_ret++;
         ret_edges.push_back(edges);
      end
      if (e_retire) e_ret++;
      if (mem_req && ready && mem_we) begin
         if (sb_q.size() == 0) begin
            check("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
         end else begin
            e = sb_q.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_strb", {28'd0, mem_wstrb}, {28'd0, e.strb});
            check("wr_data", mem_wdata, e.data);
         end
         for (int i = 0; i < 4; i++)
            if (mem_wstrb[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   task automatic exp_wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
      wr_t e;
      e.addr = addr; e.strb = strb; e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
   endtask

   task automatic wait_pc(input logic [31:0] target, input int budget, input string tag);
      int n = 0;
      while (pc !== target && n < budget) begin
         tick();
         n++;
      end
      check(tag, pc, target);
   endtask

   task automatic wait_trap(input int budget);
      int n = 0;
      while (trap !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      check("trap_set", {31'd0, trap}, 32'd1);
   endtask

   int          base, r0;
   logic [10:0] pat;

   initial begin
      rst   = 1'b1;
      ready = 1'b1;
      clear_mem();
      // ---------------- program A ----------------
      mem[0]  = enc_i(12'd5,    5'd0, 3'b000, 5'd1, OP_I);
      mem[1]  = enc_i(12'hFFD,  5'd0, 3'b000, 5'd2, OP_I);
      mem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
      mem[3]  = enc_s(12'h180, 5'd3, 5'd0, 3'b010);       exp_wr(32'h180, 4'hF, 32'h2);
      mem[4]  = enc_i(12'h100,  5'd0, 3'b000, 5'd1, OP_I);
      mem[5]  = enc_i(12'd1,    5'd0, 3'b000, 5'd2, OP_I);
      mem[6]  = enc_i(12'd31,   5'd2, 3'b001, 5'd2, OP_I);
      mem[7]  = enc_i(12'h0F1,  5'd2, 3'b110, 5'd2, OP_I);
      mem[8]  = enc_s(12'd3, 5'd2, 5'd1, 3'b000);         exp_wr(32'h100, 4'b1000, 32'hF1F1_F1F1);
      mem[9]  = enc_i(12'd3,    5'd1, 3'b000, 5'd4, OP_LD);
      mem[10] = enc_i(12'd3,    5'd1, 3'b100, 5'd5, OP_LD);
      mem[11] = enc_s(12'd4, 5'd4, 5'd1, 3'b010);         exp_wr(32'h104, 4'hF, 32'hFFFF_FFF1);
      mem[12] = enc_s(12'd8, 5'd5, 5'd1, 3'b010);         exp_wr(32'h108, 4'hF, 32'h0000_00F1);
      mem[13] = enc_i(12'd7,    5'd0, 3'b000, 5'd0, OP_I);
      mem[14] = enc_s(12'd12, 5'd0, 5'd1, 3'b010);        exp_wr(32'h10C, 4'hF, 32'h0);
      mem[15] = enc_i(12'd1,    5'd0, 3'b000, 5'd7, OP_I);
      mem[16] = enc_i(12'd31,   5'd7, 3'b001, 5'd7, OP_I);
      mem[17] = enc_i(12'h404,  5'd7, 3'b101, 5'd6, OP_I);
      mem[18] = enc_s(12'd16, 5'd6, 5'd1, 3'b010);        exp_wr(32'h110, 4'hF, 32'hF800_0000);
      mem[19] = enc_i(12'd1,    5'd0, 3'b000, 5'd8, OP_I);
      mem[20] = enc_i(12'hFFF,  5'd0, 3'b000, 5'd9, OP_I);
      mem[21] = enc_r(7'h00, 5'd9, 5'd8, 3'b011, 5'd10);
      mem[22] = enc_s(12'd20, 5'd10, 5'd1, 3'b010);       exp_wr(32'h114, 4'hF, 32'h1);
      mem[23] = enc_r(7'h00, 5'd8, 5'd9, 3'b010, 5'd11);
      mem[24] = enc_s(12'd24, 5'd11, 5'd1, 3'b010);       exp_wr(32'h118, 4'hF, 32'h1);
      mem[25] = enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd12);
      mem[26] = enc_s(12'd6, 5'd12, 5'd1, 3'b001);        exp_wr(32'h104, 4'b1100, 32'hFF02_FF02);
      mem[27] = enc_i(12'd6,    5'd1, 3'b001, 5'd13, OP_LD);
      mem[28] = enc_i(12'd6,    5'd1, 3'b101, 5'd14, OP_LD);
      mem[29] = enc_s(12'd32, 5'd13, 5'd1, 3'b010);       exp_wr(32'h120, 4'hF, 32'hFFFF_FF02);
      mem[30] = enc_s(12'd36, 5'd14, 5'd1, 3'b010);       exp_wr(32'h124, 4'hF, 32'h0000_FF02);
      mem[31] = enc_i(12'd32,   5'd1, 3'b010, 5'd15, OP_LD);
      mem[32] = enc_s(12'd40, 5'd15, 5'd1, 3'b010);       exp_wr(32'h128, 4'hF, 32'hFFFF_FF02);
      mem[33] = enc_r(7'h00, 5'd1, 5'd12, 3'b100, 5'd16);
      mem[34] = enc_r(7'h00, 5'd8, 5'd12, 3'b101, 5'd17);
      mem[35] = enc_r(7'h00, 5'd2, 5'd12, 3'b111, 5'd18);
      mem[36] = enc_r(7'h00, 5'd1, 5'd3,  3'b110, 5'd19);
      mem[37] = enc_s(12'd44, 5'd16, 5'd1, 3'b010);       exp_wr(32'h12C, 4'hF, 32'hFFFF_FE02);
      mem[38] = enc_s(12'd48, 5'd17, 5'd1, 3'b010);       exp_wr(32'h130, 4'hF, 32'h7FFF_FF81);
      mem[39] = enc_s(12'd52, 5'd18, 5'd1, 3'b010);       exp_wr(32'h134, 4'hF, 32'h8000_0000);
      mem[40] = enc_s(12'd56, 5'd19, 5'd1, 3'b010);       exp_wr(32'h138, 4'hF, 32'h0000_0102);
      mem[41] = 32'h0000_0063;

      tick();
      tick();
      // Reset state
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_pc",      pc,               32'd0);
      check("rst_result",  result,           32'd0);
      check("rst_zero",    {31'd0, zero},    32'd1);
      check("rst_retire",  {31'd0, retire},  32'd0);
      check("rst_trap",    {31'd0, trap},    32'd0);
      check("rst_e_trap",  {31'd0, e_trap},  32'd0);
      check("rst_e_pc",    e_pc,             E_PC);

      rst  = 1'b0;
      base = edges;                       // this is cycle 1
      #1;
      check("first_fetch_req",  {31'd0, mem_req}, 32'd1);
      check("first_fetch_addr", mem_addr,         32'd0);
      tick();                             // cycle 2: RV32E core in DECODE
      check("e_trap_c2", {31'd0, e_trap}, 32'd0);
      tick();                             // cycle 3: RV32E trap visible
      check("e_trap_c3", {31'd0, e_trap}, 32'd1);
      check("e_pc_hold", e_pc, E_PC);
      repeat (9) tick();                  // cycle 12: WB of ADD
      check("add_result", result, 32'd2);
      check("add_zero",   {31'd0, zero},   32'd0);
      check("add_retire", {31'd0, retire}, 32'd1);
      check("add_pc_wb",  pc, 32'd8);
      tick();
      check("pc_after3",  pc, 32'd12);
      for (int i = 0; i < 3; i++)
         check($sformatf("retire_cycle%0d", i),
               (ret_edges.size() > i) ? 32'(ret_edges[i] - base + 1) : 32'hFFFF_FFFF,
               32'(4 * (i + 1)));

      // Wait-state LW: 3 stall cycles on fetch and on the load
      wait_pc(32'd124, 600, "reach_lw");
      base = edges;
      pat  = 11'b11000111000;
      for (int c = 1; c <= 11; c++) begin
         ready = pat[c-1];
         #1;
         if (c <= 3) begin
            check($sformatf("stall_f_req%0d", c),  {31'd0, mem_req}, 32'd1);
            check($sformatf("stall_f_addr%0d", c), mem_addr, 32'd124);
         end
         if (c >= 7 && c <= 9) begin
            check($sformatf("stall_m_req%0d", c),  {31'd0, mem_req}, 32'd1);
            check($sformatf("stall_m_we%0d", c),   {31'd0, mem_we},  32'd0);
            check($sformatf("stall_m_addr%0d", c), mem_addr, 32'h120);
         end
         tick();
      end
      ready = 1'b1;
      check("lw_retire_cycle",
            (ret_edges.size() > 0) ? 32'(ret_edges[$] - base + 1) : 32'hFFFF_FFFF, 32'd11);
      check("lw_pc_next", pc, 32'd128);

      // Illegal opcode 0x63 ends program A
      wait_trap(400);
      check("trapc_pc", pc, 32'd164);
      check("progA_retires", n_ret, 32'd41);
      repeat (5) tick();
      check("trapc_no_retire", n_ret, 32'd41);
      check("trapc_req", {31'd0, mem_req}, 32'd0);
      check("progA_sb_empty", sb_q.size(), 32'd0);

      // ---------------- misaligned LW ----------------
      rst = 1'b1;
      clear_mem();
      mem[0] = enc_i(12'h102, 5'd0, 3'b000, 5'd1, OP_I);
      mem[1] = enc_i(12'd0,   5'd1, 3'b010, 5'd2, OP_LD);
      tick();
      tick();
      rst = 1'b0;
      r0  = n_ret;
      wait_trap(50);
      check("trapa_pc",      pc,          32'd4);
      check("trapa_result",  result,      32'h102);
      check("trapa_retires", n_ret - r0,  32'd1);

      // ---------------- reset during stalled store ----------------
      rst = 1'b1;
      clear_mem();
      mem[0] = enc_i(12'h100, 5'd0, 3'b000, 5'd1, OP_I);
      mem[1] = enc_s(12'd0, 5'd1, 5'd1, 3'b010);
      tick();
      tick();
      rst = 1'b0;
      wait_pc(32'd4, 20, "reach_sw");
      repeat (3) tick();                 // now in MEM
      ready = 1'b0;
      #1;
      check("sw_stall_req",  {31'd0, mem_req}, 32'd1);
      check("sw_stall_we",   {31'd0, mem_we},  32'd1);
      check("sw_stall_addr", mem_addr, 32'h100);
      tick();
      rst = 1'b1;
      #1;
      check("abort_req", {31'd0, mem_req}, 32'd0);
      check("abort_pc",  pc, 32'd0);
      ready = 1'b1;
      tick();
      tick();
      check("abort_no_write", mem[64], 32'd0);
      // Rerun after reset: the store now completes normally
      exp_wr(32'h100, 4'hF, 32'h100);
      rst = 1'b0;
      wait_pc(32'd8, 30, "rerun_sw");
      check("rerun_mem", mem[64], 32'h100);
      check("final_sb_empty", sb_q.size(), 32'd0);
      check("e_never_retired", e_ret, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multicycle_core_ris.md
# multicycle_core_ris

Parametrised multi-cycle RV32 core for R-, I- (ALU and load) and S-type instructions. It is the successor to the team's single-cycle R/I/S datapath. A state machine sequences fetch, decode, execute, memory and writeback over several clocks. Instruction and data traffic share one memory port with a ready handshake, so the core tolerates wait states. The core supports a configurable register-file depth (RV32I/RV32E) and reset vector, and halts with a trap flag on unsupported or misaligned operations.

## Interface
- NREG, 32, number of architectural registers; legal values are 32 (RV32I) and 16 (RV32E).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_req  output  1  memory request valid.
- mem_we  output  1  1 = write (store), 0 = read (fetch or load).
- mem_addr  output  32  byte address, always word-aligned (bits [1:0] = 0).
- mem_wdata  output  32  store data, replicated into the byte lanes.
- mem_wstrb  output  4  byte-lane enables for writes; 4'b0000 on reads.
- mem_rdata  input  32  read data, valid in a cycle where mem_req and mem_ready are both 1.
- mem_ready  input  1  transfer completes on a rising edge where mem_req and mem_ready are both 1.
- pc  output  32  address of the current instruction.
- result  output  32  registered ALU result of the last EXEC.
- zero  output  1  1 when that result equals 0.
- retire  output  1  one-cycle pulse when an instruction completes.
- trap  output  1  sticky halt flag.

## Operation
- Supported instructions:
  - R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type ALU: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Loads: LB, LH, LW, LBU, LHU.
  - Stores: SB, SH, SW.
- No branches or jumps. PC advances by 4 on every retire; wrap-around from 32'hFFFF_FFFC to 0 is allowed.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On handshake, latch the instruction into IR and go to DECODE.
  - DECODE: read rs1/rs2 into A/B and generate the sign-extended immediate (I or S format). An illegal opcode/funct, or any rs1/rs2/rd index >= NREG, goes to TRAP; otherwise go to EXEC.
  - EXEC: the ALU result is written to the result register. The ALU adds A+imm for load/store addresses. A misaligned address (half not 2-aligned, word not 4-aligned) goes to TRAP. Loads and stores go to MEM; ALU instructions go to WB.
  - MEM: mem_req=1, mem_addr={result[31:2],2'b00}.
    - Stores: mem_we=1, with strobe selecting lanes by result[1:0]. On handshake: retire, pc+=4, go to FETCH.
    - Loads: latch mem_rdata and go to WB.
  - WB: write rd. Load data is shifted by addr[1:0], then sign- or zero-extended per funct3. Then retire, pc+=4, go to FETCH.
  - TRAP: terminal state with trap=1 and mem_req=0. Only rst leaves it.
- Register x0 reads as 0; writes to it are discarded.
- Shift amounts use B[4:0] for register shifts or imm[4:0] for immediate shifts.
- SLT/SLTI compare signed; SLTU/SLTIU compare unsigned.
- Memory bus rules:
  - mem_addr, mem_we, mem_wdata and mem_wstrb are stable while mem_req=1 and no handshake has occurred.
  - mem_req never drops before the handshake.
  - mem_ready while mem_req=0 is ignored.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State: FETCH, pc=RESET_PC, all registers 0, IR=0.
  - Outputs: result=0, zero=1, retire=0, trap=0, mem_req=0.
- The first FETCH request is asserted in the first cycle after rst deasserts.
- Latency with zero wait states (mem_ready tied 1), counting cycles from the FETCH cycle:
  - ALU instructions: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Loads: 5 cycles.
  - Stores: 4 cycles.
- Each cycle of mem_ready=0 during FETCH or MEM adds one cycle.
- retire is high in the WB cycle (ALU and load) or in the MEM handshake cycle (store).
  - The register write and the pc update take effect at the end of that cycle.
  - The next FETCH presents the new pc.
- Reset asserted mid-transaction aborts it:
  - mem_req drops immediately.
  - A pending store does not complete, because the write is qualified by mem_req.
- A trap detected in DECODE or EXEC causes:
  - no register write;
  - no pc change (pc holds the faulting instruction);
  - no retire pulse;
  - trap=1 from the cycle after detection.

## Test plan
- Reset and ALU instructions:
  - Stimulus: assert rst, release it, with memory holding ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2 and mem_ready=1.
  - Response: x3=2, result=2, zero=0; retire pulses in cycles 4, 8 and 12; pc=12 afterwards.
- Stores and loads with lane handling:
  - Stimulus: x1=0x100, x2=0x8000_00F1; run SB x2,3(x1), then LB x4,3(x1), then LBU x5,3(x1).
  - Response: the store shows wstrb=4'b1000 at addr 0x100; x4=0xFFFF_FFF1; x5=0x0000_00F1.
- Wait states:
  - Stimulus: hold mem_ready=0 for 3 cycles on both the fetch and the load of LW.
  - Response: the load completes in 11 cycles; address and control stay stable throughout the stall.
- Traps:
  - Stimulus (a): LW at address 0x102. Response: trap=1, pc unchanged, no bus write.
  - Stimulus (b): NREG=16 and ADD x17,x1,x2. Response: trap in DECODE.
  - Stimulus (c): opcode 7'h63 (branch). Response: trap.
- x0 and shifts:
  - Stimulus: ADDI x0,x0,7; then SRAI x6,x7,4 with x7=0x8000_0000.
  - Response: x0 reads 0; x6=0xF800_0000. SLTU of 1 vs 0xFFFF_FFFF gives 1.
- Reset mid-store:
  - Stimulus: assert rst while MEM is stalled with mem_req=1 and mem_we=1.
  - Response: mem_req=0 within the same cycle, no write reaches memory, and pc=RESET_PC.
